wtm_accum: RTL and testbench
============================

WTM_ACCUM -- requirements
Module: wtm_accum

Interface
REQ-001 The block SHALL have parameter N_TERMS, default 4, number of products summed per result (legal range 2..15).
REQ-002 The block SHALL have parameter ACC_W, default 11, accumulator and sum width in bits (legal range 10..16).
REQ-003 The block SHALL have port clock, input, 1, single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1, product word is present this cycle.
REQ-006 The block SHALL have port in_ready, output, 1, block accepts a product this cycle.
REQ-007 The block SHALL have port product, input, 10, unsigned multiplier result (5x5 product).
REQ-008 The block SHALL have port prod_cout, input, 1, multiplier carry-out flag accompanying product.
REQ-009 The block SHALL have port clear, input, 1, synchronous abort of the current accumulation.
REQ-010 The block SHALL have port sum, output, ACC_W, completed accumulation result.
REQ-011 The block SHALL have port sum_valid, output, 1, sum is valid and held.
REQ-012 The block SHALL have port sum_ready, input, 1, consumer takes sum this cycle.
REQ-013 The block SHALL have port overflow, output, 1, sticky error flag for the current accumulation.
REQ-014 The block SHALL have port count, output, 4, number of products accepted in the current accumulation.

Function
REQ-015 The block SHALL implement a two-state FSM: ACCUM (in_ready=1, sum_valid=0) and HOLD (in_ready=0, sum_valid=1).
REQ-016 A product SHALL be accepted only on a rising edge where in_valid=1 and in_ready=1.
REQ-017 On acceptance, the block SHALL update the accumulator to (accumulator + zero-extended product) mod 2^ACC_W, and SHALL increment count by 1.
REQ-018 On acceptance, overflow SHALL be set if the addition carries out of bit ACC_W-1 or if prod_cout=1; once set, it SHALL remain set until the accumulation ends.
REQ-019 Accepting the N_TERMS-th product SHALL move the FSM to HOLD on that same edge, with sum equal to the final accumulator value, so that sum_valid rises exactly one cycle after the last product is presented.
REQ-020 In HOLD, sum, overflow and count (=N_TERMS) SHALL stay stable until the handshake completes; in_valid SHALL be ignored.
REQ-021 In HOLD, sum_ready=1 SHALL return the FSM to ACCUM on the next edge with accumulator=0, count=0 and overflow=0.
REQ-022 sum_ready=1 while in ACCUM SHALL have no effect.
REQ-023 Cycles with in_valid=0 (bubbles) SHALL leave the accumulator, count and overflow unchanged.
REQ-024 When clear=1, on the next edge the block SHALL enter ACCUM with accumulator=0, count=0, overflow=0 and sum_valid=0, from either state, and the product presented in that cycle SHALL be discarded.
REQ-025 Priority SHALL be reset > clear > handshake.
REQ-026 All outputs SHALL be driven directly from registers or from FSM state; there SHALL be no combinational path from input to output.

Reset
REQ-027 When reset=1 at a rising edge, the block SHALL enter ACCUM with sum=0, sum_valid=0, in_ready=1, overflow=0 and count=0.
REQ-028 Reset asserted mid-accumulation or in HOLD SHALL discard all partial or held results; no sum_valid pulse SHALL follow.

Verification
REQ-029 Reset scenario: hold reset for 2 cycles, then release -> in_ready=1, sum_valid=0, sum=0, count=0, overflow=0.
REQ-030 Basic sum scenario: products 24, 0, 400, 31 presented on consecutive cycles with sum_ready=0 -> one cycle later sum_valid=1, sum=455, overflow=0, in_ready=0, count=4, all stable for 3 idle cycles; then sum_ready=1 -> next cycle sum_valid=0, count=0.
REQ-031 Wrap scenario: products 1023, 1023, 1023, 1 -> sum=1022 (3070 mod 2048), overflow=1.
REQ-032 Carry-flag scenario: products 5, 0, 0, 0 with prod_cout=1 on the first product only -> sum=5, overflow=1.
REQ-033 Bubble/abort scenario: 3, idle, 8, idle, then clear=1 -> count=0; follow with 1, 1, 1, 1 -> sum=4, overflow=0.
REQ-034 Backpressure scenario: in HOLD, drive in_valid=1 with product=100 for 2 cycles, then assert sum_ready -> the held sum is unchanged, product 100 is not accepted, and count=0 after the handshake.

Source files
------------

// File: rtl/wtm_accum.sv
// Product accumulator for the Wallace-tree multiplier datapath.
// Sums N_TERMS unsigned products, then holds the result until the consumer takes it.
module wtm_accum #(
  parameter int unsigned N_TERMS = 4,
  parameter int unsigned ACC_W   = 11
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [9:0]       product,
  input  logic             prod_cout,
  input  logic             clear,
  output logic [ACC_W-1:0] sum,
  output logic             sum_valid,
  input  logic             sum_ready,
  output logic             overflow,
  output logic [3:0]       count
);

  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_HOLD  = 1'b1;
  localparam logic [3:0] LAST_IDX = 4'(N_TERMS - 1);

  logic [0:0]       state;
  logic [ACC_W-1:0] acc;
  logic             ovf;
  logic [3:0]       cnt;
  logic [ACC_W:0]   add_full;
  logic             accept;

  assign accept   = in_valid && (state == ST_ACCUM);
  // Extra top bit of the adder captures the carry out of the accumulator.
  assign add_full = {1'b0, acc} + {{(ACC_W + 1 - 10){1'b0}}, product};

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      state <= ST_ACCUM;
      acc   <= '0;
      ovf   <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        ST_ACCUM: begin
          if (accept) begin
            acc <= add_full[ACC_W-1:0];
            ovf <= ovf | add_full[ACC_W] | prod_cout;
            cnt <= cnt + 4'd1;
            if (cnt == LAST_IDX) state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (sum_ready) begin
            state <= ST_ACCUM;
            acc   <= '0;
            ovf   <= 1'b0;
            cnt   <= '0;
          end
        end
        default: state <= ST_ACCUM;
      endcase
    end
  end

  assign in_ready  = (state == ST_ACCUM);
  assign sum_valid = (state == ST_HOLD);
  assign sum       = acc;
  assign overflow  = ovf;
  assign count     = cnt;

endmodule

// File: tb/tb_wtm_accum.sv
// Self-checking bench for wtm_accum: directed scenarios plus randomized traffic
// compared against a transaction-level model (running total, term count, flags).
module tb_wtm_accum;
  localparam int N   = 4;
  localparam int AW  = 11;
  localparam int MOD = 1 << AW;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [9:0]    product = '0;
  logic          prod_cout = 1'b0;
  logic          clear = 1'b0;
  logic [AW-1:0] sum;
  logic          sum_valid;
  logic          sum_ready = 1'b0;
  logic          overflow;
  logic [3:0]    count;

  int checks = 0;
  int errors = 0;

  // Reference model: true (unbounded) running total, terms taken, carry flag seen, holding.
  int m_total = 0;
  int m_cnt   = 0;
  bit m_cout  = 1'b0;
  bit m_hold  = 1'b0;

  wtm_accum #(.N_TERMS(N), .ACC_W(AW)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .product(product), .prod_cout(prod_cout), .clear(clear), .sum(sum),
    .sum_valid(sum_valid), .sum_ready(sum_ready), .overflow(overflow), .count(count)
  );

  always #5 clock = ~clock;

  function automatic logic [AW-1:0] exp_sum();
    return AW'(m_total % MOD);
  endfunction

  function automatic logic exp_ovf();
    return (m_total >= MOD) || m_cout;
  endfunction

  task automatic model_zero();
    m_total = 0; m_cnt = 0; m_cout = 1'b0; m_hold = 1'b0;
  endtask

  // Drive one cycle of inputs, advance the model across the edge, land 1 time unit after it.
  task automatic cyc(input logic rst, input logic v, input int p, input logic c,
                     input logic clr, input logic rdy);
    reset = rst; in_valid = v; product = 10'(p); prod_cout = c; clear = clr; sum_ready = rdy;
    @(posedge clock);
    if (rst || clr) model_zero();
    else if (!m_hold && v) begin
      m_total += p; m_cnt++; m_cout |= c;
      if (m_cnt == N) m_hold = 1'b1;
    end else if (m_hold && rdy) model_zero();
    #1;
    reset = 1'b0; in_valid = 1'b0; clear = 1'b0; sum_ready = 1'b0; prod_cout = 1'b0;
  endtask

  task automatic test_reset();
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 1, 77, 1, 0, 1);
    checks++;
    if (in_ready !== 1'b1 || sum_valid !== 1'b0 || sum !== '0 || count !== 4'd0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset: in_ready=%b sum_valid=%b sum=%0d count=%0d overflow=%b, need 1 0 0 0 0",
               in_ready, sum_valid, sum, count, overflow);
    end
  endtask

  task automatic test_basic_sum();
    int vals[4] = '{24, 0, 400, 31};
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, vals[i], 0, 0, 0);
      if (i < 3) begin
        checks++;
        if (sum_valid !== 1'b0 || count !== 4'(i + 1)) begin
          errors++;
          $display("FAIL basic_partial[%0d]: sum_valid=%b count=%0d, need 0 %0d", i, sum_valid, count, i + 1);
        end
      end
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (sum_valid !== 1'b1 || sum !== 11'd455 || overflow !== 1'b0 || in_ready !== 1'b0 || count !== 4'd4) begin
        errors++;
        $display("FAIL basic_hold[%0d]: sum_valid=%b sum=%0d overflow=%b in_ready=%b count=%0d, need 1 455 0 0 4",
                 k, sum_valid, sum, overflow, in_ready, count);
      end
      if (k < 3) cyc(0, 0, 0, 0, 0, 0);
    end
    cyc(0, 0, 0, 0, 0, 1);
    checks++;
    if (sum_valid !== 1'b0 || count !== 4'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_handshake: sum_valid=%b count=%0d in_ready=%b, need 0 0 1", sum_valid, count, in_ready);
    end
    cyc(0, 0, 0, 0, 0, 1);
    checks++;
    if (sum_valid !== 1'b0 || count !== 4'd0) begin
      errors++;
      $display("FAIL ready_in_accum: sum_valid=%b count=%0d, need 0 0", sum_valid, count);
    end
  endtask

  task automatic test_wrap();
    int vals[4] = '{1023, 1023, 1023, 1};
    for (int i = 0; i < 4; i++) cyc(0, 1, vals[i], 0, 0, 0);
    checks++;
    if (sum_valid !== 1'b1 || sum !== 11'd1022 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL wrap: sum_valid=%b sum=%0d overflow=%b, need 1 1022 1", sum_valid, sum, overflow);
    end
    cyc(0, 0, 0, 0, 0, 1);
    checks++;
    if (overflow !== 1'b0 || sum_valid !== 1'b0) begin
      errors++;
      $display("FAIL wrap_release: overflow=%b sum_valid=%b, need 0 0", overflow, sum_valid);
    end
  endtask

  task automatic test_carry_flag();
    cyc(0, 1, 5, 1, 0, 0);
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL carry_set: overflow=%b, need 1", overflow);
    end
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0, 0);
    checks++;
    if (sum_valid !== 1'b1 || sum !== 11'd5 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL carry_flag: sum_valid=%b sum=%0d overflow=%b, need 1 5 1", sum_valid, sum, overflow);
    end
    cyc(0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_bubble_abort();
    cyc(0, 1, 3, 0, 0, 0);
    cyc(0, 0, 9, 1, 0, 0);
    cyc(0, 1, 8, 0, 0, 0);
    cyc(0, 0, 9, 1, 0, 0);
    checks++;
    if (count !== 4'd2 || sum !== 11'd11 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL bubble: count=%0d sum=%0d overflow=%b, need 2 11 0", count, sum, overflow);
    end
    cyc(0, 1, 7, 1, 1, 0);
    checks++;
    if (count !== 4'd0 || sum !== '0 || overflow !== 1'b0 || sum_valid !== 1'b0) begin
      errors++;
      $display("FAIL clear_accum: count=%0d sum=%0d overflow=%b sum_valid=%b, need 0 0 0 0",
               count, sum, overflow, sum_valid);
    end
    for (int i = 0; i < 4; i++) cyc(0, 1, 1, 0, 0, 0);
    checks++;
    if (sum_valid !== 1'b1 || sum !== 11'd4 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL after_clear: sum_valid=%b sum=%0d overflow=%b, need 1 4 0", sum_valid, sum, overflow);
    end
    cyc(0, 0, 0, 0, 1, 0);
    checks++;
    if (sum_valid !== 1'b0 || in_ready !== 1'b1 || count !== 4'd0 || sum !== '0) begin
      errors++;
      $display("FAIL clear_hold: sum_valid=%b in_ready=%b count=%0d sum=%0d, need 0 1 0 0",
               sum_valid, in_ready, count, sum);
    end
  endtask

  task automatic test_backpressure();
    int vals[4] = '{10, 20, 30, 40};
    for (int i = 0; i < 4; i++) cyc(0, 1, vals[i], 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      cyc(0, 1, 100, 1, 0, 0);
      checks++;
      if (sum_valid !== 1'b1 || sum !== 11'd100 || count !== 4'd4 || overflow !== 1'b0) begin
        errors++;
        $display("FAIL backpressure[%0d]: sum_valid=%b sum=%0d count=%0d overflow=%b, need 1 100 4 0",
                 k, sum_valid, sum, count, overflow);
      end
    end
    cyc(0, 1, 100, 0, 0, 1);
    checks++;
    if (count !== 4'd0 || sum_valid !== 1'b0 || sum !== '0) begin
      errors++;
      $display("FAIL backpressure_release: count=%0d sum_valid=%b sum=%0d, need 0 0 0", count, sum_valid, sum);
    end
  endtask

  task automatic test_reset_mid();
    cyc(0, 1, 50, 1, 0, 0);
    cyc(0, 1, 60, 0, 0, 0);
    cyc(1, 1, 70, 0, 0, 0);
    checks++;
    if (count !== 4'd0 || sum !== '0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: count=%0d sum=%0d overflow=%b, need 0 0 0", count, sum, overflow);
    end
    for (int i = 0; i < 4; i++) cyc(0, 1, 2, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (sum_valid !== 1'b0 || in_ready !== 1'b1 || count !== 4'd0) begin
        errors++;
        $display("FAIL reset_hold[%0d]: sum_valid=%b in_ready=%b count=%0d, need 0 1 0",
                 i, sum_valid, in_ready, count);
      end
      cyc(0, 0, 0, 0, 0, 0);
    end
  endtask

  task automatic test_random();
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      logic rv, rc, rclr, rrdy, rrst;
      int   rp;
      rv   = ($urandom % 4) != 0;
      rp   = ($urandom % 4 == 0) ? 1023 : int'($urandom % 1024);
      rc   = ($urandom % 10) == 0;
      rclr = ($urandom % 30) == 0;
      rrdy = ($urandom % 3) == 0;
      rrst = ($urandom % 120) == 0;
      cyc(rrst, rv, rp, rc, rclr, rrdy);
      checks++;
      if (sum_valid !== m_hold || in_ready !== !m_hold || count !== 4'(m_cnt) ||
          overflow !== exp_ovf() || (m_hold && sum !== exp_sum())) begin
        errors++;
        $display("FAIL random[%0d]: sum_valid=%b in_ready=%b count=%0d overflow=%b sum=%0d, need %b %b %0d %b %0d",
                 i, sum_valid, in_ready, count, overflow, sum, m_hold, !m_hold, m_cnt, exp_ovf(), exp_sum());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_sum();
    test_wrap();
    test_carry_flag();
    test_bubble_abort();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, need completion");
    $fatal(1, "timeout");
  end
endmodule
